if_stage: RTL

Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID register. It owns the fetch PC and runs a request/acknowledge handshake to instruction memory. Returned instructions are buffered in a 2-entry FIFO, and the FIFO head is presented as InstrF/PCF/PCPlus4F. It handles stalls from the hazard unit and branch/jump redirects from EX, including squashing an in-flight fetch.

---
 rtl/if_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, imem request/ack handshake, 2-entry fetch FIFO, redirect squash.
// Optional performance counters (FetchCount, SquashCount) are enabled by defining IF_STAGE_PERF_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        FetchValidF
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] SquashCount
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SQUASH = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] raddr_q, raddr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] instr0_q, instr0_d, pc0_q, pc0_d;
    logic [31:0] instr1_q, instr1_d, pc1_q, pc1_d;

    logic        req_s;
    logic        push_s;
    logic [31:0] push_pc_s;
    logic        pop_s;
    logic        wr_slot1_s;
    logic [31:0] target_s;

    assign target_s = PCTargetE & 32'hFFFF_FFFC;

    // Request generation; reset masks the request so an abandoned fetch drops immediately
    always_comb begin
        req_s     = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            S_IDLE: begin
                req_s     = (count_q < 2'd2) & ~PCSrcE;
                imem_addr = pc_q;
            end
            S_WAIT, S_SQUASH: begin
                req_s     = 1'b1;
                imem_addr = raddr_q;
            end
            default: begin
                req_s     = 1'b0;
                imem_addr = pc_q;
            end
        endcase
    end

    assign imem_req = req_s & ~reset;

    assign FetchValidF = (count_q != 2'd0);
    assign InstrF      = FetchValidF ? instr0_q : NOP_INSTR;
    assign PCF         = FetchValidF ? pc0_q : pc_q;
    assign PCPlus4F    = PCF + 32'd4;
    assign pop_s       = FetchValidF & ~StallF & ~PCSrcE;

    // Fetch FSM and PC update; redirect overrides push and stall
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        raddr_d   = raddr_q;
        push_s    = 1'b0;
        push_pc_s = pc_q;
        case (state_q)
            S_IDLE: begin
                if (PCSrcE) begin
                    pc_d = target_s;
                end else if (req_s) begin
                    raddr_d = pc_q;
                    if (imem_ack) begin
                        push_s    = 1'b1;
                        push_pc_s = pc_q;
                        pc_d      = pc_q + 32'd4;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    pc_d    = target_s;
                    state_d = imem_ack ? S_IDLE : S_SQUASH;
                end else if (imem_ack) begin
                    push_s    = 1'b1;
                    push_pc_s = raddr_q;
                    pc_d      = raddr_q + 32'd4;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_SQUASH: begin
                state_d = imem_ack ? S_IDLE : S_SQUASH;
                if (PCSrcE) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO: entry 0 is the head; a new entry lands behind whatever survives this cycle's pop
    always_comb begin
        count_d    = count_q;
        instr0_d   = instr0_q;
        pc0_d      = pc0_q;
        instr1_d   = instr1_q;
        pc1_d      = pc1_q;
        wr_slot1_s = (count_q == 2'd2) | ((count_q == 2'd1) & ~pop_s);
        if (PCSrcE) begin
            count_d = 2'd0;
        end else begin
            if (pop_s) begin
                instr0_d = instr1_q;
                pc0_d    = pc1_q;
            end else begin
                instr0_d = instr0_q;
                pc0_d    = pc0_q;
            end
            if (push_s) begin
                if (wr_slot1_s) begin
                    instr1_d = imem_rdata;
                    pc1_d    = push_pc_s;
                end else begin
                    instr0_d = imem_rdata;
                    pc0_d    = push_pc_s;
                end
            end else begin
                instr1_d = instr1_q;
            end
            count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            raddr_q  <= RESET_PC;
            count_q  <= 2'd0;
            instr0_q <= NOP_INSTR;
            pc0_q    <= RESET_PC;
            instr1_q <= NOP_INSTR;
            pc1_q    <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            raddr_q  <= raddr_d;
            count_q  <= count_d;
            instr0_q <= instr0_d;
            pc0_q    <= pc0_d;
            instr1_q <= instr1_d;
            pc1_q    <= pc1_d;
        end
    end

`ifdef IF_STAGE_PERF_EN
    logic        drop_s;
    logic [31:0] fetch_cnt_q, squash_cnt_q;

    assign drop_s = imem_ack & ((state_q == S_SQUASH) | ((state_q == S_WAIT) & PCSrcE));

    // Performance counters, wrapping at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q  <= 32'd0;
            squash_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_q + {31'd0, push_s};
            squash_cnt_q <= squash_cnt_q + {31'd0, drop_s};
        end
    end

    assign FetchCount  = fetch_cnt_q;
    assign SquashCount = squash_cnt_q;
`endif

endmodule
